// File: rtl/m_pte_responder.sv
// m_pte_responder: MMU page-walk PTE responder with a direct-mapped write-through PTE cache
// in front of a single-outstanding DRAM request/acknowledge port.
module m_pte_responder #(
  parameter int PC_ENTRIES = 4,
  parameter int PC_IDX     = 2
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        mmu_req,
  input  logic        mmu_we,
  input  logic [31:0] mmu_addr,
  input  logic [31:0] mmu_wdata,
  output logic        mmu_busy,
  output logic [31:0] mmu_odata,
  input  logic        flush,
  output logic        dram_req,
  output logic        dram_we,
  output logic [31:0] dram_addr,
  output logic [31:0] dram_wdata,
  input  logic        dram_ack,
  input  logic [31:0] dram_rdata
);
  localparam int TW = 30 - PC_IDX;
  // bit 1 marks the states that own the DRAM port
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIT  = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] WR   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           odata_q, odata_d;
  logic                  fpend_q, fpend_d;
  logic [PC_ENTRIES-1:0] valid_q, valid_d;
  logic [TW-1:0]         tag_q [PC_ENTRIES];
  logic [TW-1:0]         tag_d [PC_ENTRIES];
  logic [31:0]           data_q [PC_ENTRIES];
  logic [31:0]           data_d [PC_ENTRIES];

  logic [PC_IDX-1:0] req_idx, cur_idx;
  logic [TW-1:0]     req_tag, cur_tag;
  logic              hit, upd_ok;

  assign req_idx = mmu_addr[PC_IDX+1:2];
  assign req_tag = mmu_addr[31:PC_IDX+2];
  assign cur_idx = addr_q[PC_IDX+1:2];
  assign cur_tag = addr_q[31:PC_IDX+2];
  assign hit     = valid_q[req_idx] && tag_q[req_idx] == req_tag;
  // a flush seen anywhere during the transfer, including the ack edge, cancels the cache update
  assign upd_ok  = dram_ack && !fpend_q && !flush;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    odata_d = odata_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (state_q == IDLE) begin
      if (mmu_req) begin
        addr_d  = mmu_addr & ~32'h3;
        wdata_d = mmu_wdata;
        state_d = mmu_we ? WR : (hit ? HIT : RD);
      end
    end else if (state_q == HIT) begin
      odata_d = data_q[cur_idx];
      state_d = IDLE;
    end else if (dram_ack) begin
      state_d = IDLE;
      if (state_q == RD) begin
        odata_d = dram_rdata;
        if (upd_ok) begin
          valid_d[cur_idx] = 1'b1;
          tag_d[cur_idx]   = cur_tag;
          data_d[cur_idx]  = dram_rdata;
        end
      end else if (upd_ok && valid_q[cur_idx] && tag_q[cur_idx] == cur_tag) begin
        data_d[cur_idx] = wdata_q;
      end
    end
    fpend_d = (state_d == IDLE) ? 1'b0 : (fpend_q | (flush & state_q[1]));
    if (flush) valid_d = '0;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      odata_q <= '0;
      fpend_q <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      odata_q <= odata_d;
      fpend_q <= fpend_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign mmu_busy   = state_q != IDLE;
  assign mmu_odata  = odata_q;
  assign dram_req   = state_q[1];
  assign dram_we    = state_q == WR;
  assign dram_addr  = addr_q;
  assign dram_wdata = wdata_q;
endmodule

// File: tb/tb_m_pte_responder.sv
// tb_m_pte_responder: transaction-level cache/DRAM model driving per-cycle expectations,
// directed scenarios with literal pins, then randomized traffic.
module tb_m_pte_responder;
  logic        CLK = 1'b0, RST_X = 1'b0;
  logic        mmu_req = 1'b0, mmu_we = 1'b0, flush = 1'b0, dram_ack = 1'b0;
  logic [31:0] mmu_addr = '0, mmu_wdata = '0, dram_rdata = '0;
  logic        mmu_busy, dram_req, dram_we;
  logic [31:0] mmu_odata, dram_addr, dram_wdata;

  always #5 CLK = ~CLK;

  m_pte_responder #(.PC_ENTRIES(4), .PC_IDX(2)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .mmu_req(mmu_req), .mmu_we(mmu_we), .mmu_addr(mmu_addr), .mmu_wdata(mmu_wdata),
    .mmu_busy(mmu_busy), .mmu_odata(mmu_odata), .flush(flush),
    .dram_req(dram_req), .dram_we(dram_we), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_ack(dram_ack), .dram_rdata(dram_rdata)
  );

  int checks = 0, errors = 0;
  logic chk_en = 1'b0, e_busy = 1'b0, e_req = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_odata = '0;
  int req_cnt = 0;
  logic [31:0] last_wdata = '0;

  logic        m_valid [4];
  logic [27:0] m_tag   [4];
  logic [31:0] m_data  [4];
  logic [31:0] mem [logic [29:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (dram_req === 1'b1) begin
      req_cnt++;
      if (dram_we === 1'b1) last_wdata = dram_wdata;
    end
    if (chk_en) begin
      chk("busy", {31'd0, mmu_busy}, {31'd0, e_busy});
      chk("dram_req", {31'd0, dram_req}, {31'd0, e_req});
      chk("odata", mmu_odata, e_odata);
      if (e_req) begin
        chk("dram_we", {31'd0, dram_we}, {31'd0, e_we});
        chk("dram_addr", dram_addr, e_addr);
        if (e_we) chk("dram_wdata", dram_wdata, e_wdata);
      end
    end
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a[31:2]) ? mem[a[31:2]] : (a ^ 32'h5A5A_0000) * 32'd2654435761;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // f: -2 no flush, -1 flush with the request strobe, c>=0 flush in DRAM cycle c
  task automatic xact(input logic we, input logic [31:0] a, input logic [31:0] wd, input int k, input int f);
    int idx;
    logic [27:0] tg;
    logic hit, blocked;
    logic [31:0] rd;
    idx = int'(a[3:2]);
    tg = a[31:4];
    rd = '0;
    hit = !we && m_valid[idx] && m_tag[idx] == tg;
    mmu_req = 1'b1; mmu_we = we; mmu_addr = a; mmu_wdata = wd;
    flush = (f == -1);
    dram_ack = 1'($urandom_range(0, 1));
    step();
    mmu_req = 1'b0; mmu_we = 1'($urandom); mmu_addr = $urandom; mmu_wdata = $urandom;
    dram_ack = 1'b0;
    if (flush) clear_model();
    flush = 1'b0;
    blocked = 1'b0;
    e_busy = 1'b1;
    if (hit) begin
      e_req = 1'b0;
      step();
      e_odata = m_data[idx];
    end else begin
      e_req = 1'b1; e_we = we; e_addr = {a[31:2], 2'b00}; e_wdata = wd;
      for (int c = 0; c <= k; c++) begin
        dram_rdata = $urandom;
        if (c == k) begin
          rd = mem_rd(a);
          dram_rdata = rd;
          dram_ack = 1'b1;
        end
        if (c == f) flush = 1'b1;
        step();
        dram_ack = 1'b0;
        if (flush) begin
          clear_model();
          blocked = 1'b1;
        end
        flush = 1'b0;
      end
      if (we) begin
        mem[a[31:2]] = wd;
        if (!blocked && m_valid[idx] && m_tag[idx] == tg) m_data[idx] = wd;
      end else begin
        e_odata = rd;
        if (!blocked) begin
          m_valid[idx] = 1'b1; m_tag[idx] = tg; m_data[idx] = rd;
        end
      end
    end
    e_busy = 1'b0;
    e_req = 1'b0;
  endtask

  task automatic idle_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_model();
  endtask

  initial begin
    logic [31:0] t;
    int r, k, f;
    clear_model();
    t = 32'h8000_1004;
    mem[t[31:2]] = 32'h2000_00CF;
    step();
    step();
    chk("reset busy", {31'd0, mmu_busy}, 32'd0);
    chk("reset dram_req", {31'd0, dram_req}, 32'd0);
    chk("reset dram_we", {31'd0, dram_we}, 32'd0);
    chk("reset odata", mmu_odata, 32'd0);
    chk("reset dram_addr", dram_addr, 32'd0);
    chk("reset dram_wdata", dram_wdata, 32'd0);
    RST_X = 1'b1;
    chk_en = 1'b1;
    step();

    xact(1'b0, 32'h8000_1004, 32'd0, 3, -2);
    chk("first read data", mmu_odata, 32'h2000_00CF);
    chk("first read dram cycles", req_cnt, 32'd4);
    xact(1'b0, 32'h8000_1004, 32'd0, 3, -2);
    chk("reread hit no dram", req_cnt, 32'd4);
    chk("reread data", mmu_odata, 32'h2000_00CF);
    xact(1'b1, 32'h8000_1004, 32'h2000_00CF | 32'hC0, 1, -2);
    chk("write dram cycles", req_cnt, 32'd6);
    chk("write dram data", last_wdata, 32'h2000_00CF);
    xact(1'b0, 32'h8000_1004, 32'd0, 2, -2);
    chk("read after write hits", req_cnt, 32'd6);
    xact(1'b1, 32'h8000_2008, 32'h1234_5678, 0, -2);
    chk("uncached write cycles", req_cnt, 32'd7);
    xact(1'b0, 32'h8000_2008, 32'd0, 2, -2);
    chk("no-allocate read misses", req_cnt, 32'd10);
    chk("no-allocate read data", mmu_odata, 32'h1234_5678);
    xact(1'b0, 32'h8000_1014, 32'd0, 0, -2);
    xact(1'b0, 32'h8000_1004, 32'd0, 0, -2);
    chk("conflict both miss", req_cnt, 32'd12);
    xact(1'b0, 32'h8000_1014, 32'd0, 2, 2);
    xact(1'b0, 32'h8000_1014, 32'd0, 0, -2);
    chk("flush at ack blocks fill", req_cnt, 32'd16);
    xact(1'b0, 32'h8000_1008, 32'd0, 0, -2);
    idle_flush();
    xact(1'b0, 32'h8000_1014, 32'd0, 0, -2);
    xact(1'b0, 32'h8000_1008, 32'd0, 0, -2);
    chk("idle flush invalidates", req_cnt, 32'd19);

    chk_en = 1'b0;
    mmu_req = 1'b1; mmu_we = 1'b0; mmu_addr = 32'h8000_3000;
    step();
    mmu_req = 1'b0;
    step();
    chk("pre-reset dram_req", {31'd0, dram_req}, 32'd1);
    RST_X = 1'b0;
    #1;
    chk("async reset dram_req", {31'd0, dram_req}, 32'd0);
    chk("async reset busy", {31'd0, mmu_busy}, 32'd0);
    chk("async reset odata", mmu_odata, 32'd0);
    step();
    RST_X = 1'b1;
    clear_model();
    e_odata = '0; e_busy = 1'b0; e_req = 1'b0;
    chk_en = 1'b1;
    step();
    r = req_cnt;
    xact(1'b0, 32'h8000_1004, 32'd0, 1, -2);
    chk("post-reset read misses", req_cnt - r, 32'd2);

    for (int n = 0; n < 400; n++) begin
      t = (($urandom_range(0, 3) == 0) ? 32'h8000_5000 : 32'h8000_1000)
          + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3));
      k = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      f = (r == 0) ? -1 : (r == 1) ? $urandom_range(0, k) : -2;
      xact($urandom_range(0, 3) == 0, t, $urandom, k, f);
      r = $urandom_range(0, 19);
      if (r == 0) idle_flush();
      else if (r == 1) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
